alu_serial_addsub: RTL and testbench

- Parametrised, digit-serial add/subtract engine for the CPU datapath.
- Successor to the fixed two-pass 8-bit nibble ALU add path. Processes a W-bit operand pair one D-bit digit per cycle, LSB digit first.
- Produces result and Z/N/H/C flags, so the same block serves 8-bit ALU ops and 16-bit ADD HL,rr / ADD SP,e.
- Start/busy/done handshake toward the microcode sequencer.

---
 rtl/alu_serial_pkg.sv | 17 +
 rtl/alu_digit_slice.sv | 27 ++
 rtl/alu_serial_addsub.sv | 98 +++++++++
 tb/tb_alu_serial_addsub.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: op codes, FSM states and flag indices shared by the serial add/sub engine
package alu_serial_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SBC  = 3'b011,
    OP_CP   = 3'b100,
    OP_BADD = 3'b110,
    OP_BSUB = 3'b111
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam int FLAG_C = 0;
  localparam int FLAG_H = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;
endpackage

// File: rtl/alu_digit_slice.sv
// alu_digit_slice: D-bit add with carry, invert-b for subtract; BCD correction when ALU_SERIAL_BCD_EN
module alu_digit_slice #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  input  logic         sub,
`ifdef ALU_SERIAL_BCD_EN
  input  logic         bcd,
`endif
  output logic [D-1:0] s,
  output logic         cout
);
  logic [D:0] raw;
  assign raw = {1'b0, a} + {1'b0, sub ? ~b : b} + {{D{1'b0}}, cin};
`ifdef ALU_SERIAL_BCD_EN
  logic adj;
  // decimal add corrects on >9 or carry; decimal subtract corrects on borrow (no carry)
  assign adj  = bcd & (sub ? ~raw[D] : (raw[D] | (raw[D-1:0] > D'(9))));
  assign s    = adj ? raw[D-1:0] + (sub ? D'(10) : D'(6)) : raw[D-1:0];
  assign cout = raw[D] | (adj & ~sub);
`else
  assign s    = raw[D-1:0];
  assign cout = raw[D];
`endif
endmodule

// File: rtl/alu_serial_addsub.sv
// alu_serial_addsub: digit-serial add/subtract with Z/N/H/C flags and start/busy/done handshake
// Optional decimal ops BADD/BSUB enabled by defining ALU_SERIAL_BCD_EN.
module alu_serial_addsub
  import alu_serial_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_h,
  output logic         flag_c
);
  localparam int K  = W / D;
  localparam int KW = $clog2(K);
  state_t state, state_n;
  op_t op_q;
  logic [W-1:0] a_q, b_q, r;
  logic [W-D-1:0] acc;
  logic [KW-1:0] k;
  logic cin_q, carry, h_q, sub, c_in, cout, last;
  logic [D-1:0] s;
  // carry is held as a true carry; subtract flags report its inverse as borrow
  assign sub  = op_q == OP_SUB || op_q == OP_SBC || op_q == OP_CP || op_q == OP_BSUB;
  assign c_in = (k == '0) ? sub ^ ((op_q == OP_ADC || op_q == OP_SBC) & cin_q) : carry;
  assign last = k == KW'(K - 1);
  assign r    = {s, acc};
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  alu_digit_slice #(.D(D)) u_slice (
    .a    (a_q[int'(k)*D +: D]),
    .b    (b_q[int'(k)*D +: D]),
    .cin  (c_in),
    .sub  (sub),
`ifdef ALU_SERIAL_BCD_EN
    .bcd  (op_q == OP_BADD || op_q == OP_BSUB),
`endif
    .s    (s),
    .cout (cout)
  );
  always_comb begin
    state_n = (state == S_IDLE && start) ? S_RUN :
              (state == S_RUN && last)   ? S_DONE :
              (state == S_DONE)          ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      k      <= '0;
      carry  <= 1'b0;
      h_q    <= 1'b0;
      acc    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_h <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        op_q  <= op_t'(op);
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
        k     <= '0;
        carry <= 1'b0;
      end
      if (state == S_RUN) begin
        k     <= k + 1'b1;
        carry <= cout;
        acc   <= r[W-1:D];
        if (k == KW'(K - 2)) h_q <= cout;
        // outputs change only here, so they stay stable through the next operation's RUN
        if (last) begin
          result <= (op_q == OP_CP) ? a_q : r;
          flag_z <= r == '0;
          flag_n <= sub;
          flag_h <= sub ^ h_q;
          flag_c <= sub ^ cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_serial_addsub.sv
// tb_alu_serial_addsub: directed checks of W=8 and W=16 instances of alu_serial_addsub
module tb_alu_serial_addsub;
  logic clk = 1'b0, reset = 1'b1, start8 = 1'b0, start16 = 1'b0, cin = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a8 = '0, b8 = '0, result8;
  logic [15:0] a16 = '0, b16 = '0, result16;
  logic busy8, done8, z8, n8, h8, c8, busy16, done16, z16, n16, h16, c16;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_serial_addsub #(.W(8), .D(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a(a8), .b(b8), .cin(cin),
    .busy(busy8), .done(done8), .result(result8),
    .flag_z(z8), .flag_n(n8), .flag_h(h8), .flag_c(c8)
  );
  alu_serial_addsub #(.W(16), .D(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op), .a(a16), .b(b16), .cin(cin),
    .busy(busy16), .done(done16), .result(result16),
    .flag_z(z16), .flag_n(n16), .flag_h(h16), .flag_c(c16)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // start one operation and return in its done cycle; lat counts cycles from the accept cycle
  task automatic run(input bit sel, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic ci, output int lat, output int bpre, output logic bdone);
    op = o; cin = ci; a8 = x[7:0]; b8 = y[7:0]; a16 = x; b16 = y;
    if (sel) start16 = 1'b1; else start8 = 1'b1;
    step;
    start8 = 1'b0; start16 = 1'b0;
    lat = 1; bpre = 0;
    while (!(sel ? done16 : done8) && lat < 20) begin
      bpre += int'(sel ? busy16 : busy8);
      step;
      lat++;
    end
    bdone = sel ? busy16 : busy8;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) step;
    checks++;
    if ({busy8, done8, result8, z8, n8, h8, c8} !== 14'h0) begin
      errors++; $display("FAIL reset8 got %b want 0", {busy8, done8, result8, z8, n8, h8, c8});
    end
    checks++;
    if ({busy16, done16, result16, z16, n16, h16, c16} !== 22'h0) begin
      errors++; $display("FAIL reset16 got %b want 0", {busy16, done16, result16, z16, n16, h16, c16});
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_add8;
    int lat, bpre; logic bd;
    run(1'b0, 3'b000, 16'h003A, 16'h00C6, 1'b0, lat, bpre, bd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add8_latency got %0d want 3", lat); end
    checks++; if (bpre !== 2 || bd !== 1'b1) begin errors++; $display("FAIL add8_busy got pre=%0d at_done=%b want 2 1", bpre, bd); end
    checks++; if (result8 !== 8'h00) begin errors++; $display("FAIL add8_result got %h want 00", result8); end
    checks++; if ({z8, n8, h8, c8} !== 4'b1011) begin errors++; $display("FAIL add8_flags got %b want 1011", {z8, n8, h8, c8}); end
    step;
  endtask

  task automatic test_sbc_cp8;
    int lat, bpre; logic bd;
    run(1'b0, 3'b011, 16'h003B, 16'h004F, 1'b1, lat, bpre, bd);
    checks++; if (result8 !== 8'hEB) begin errors++; $display("FAIL sbc8_result got %h want EB", result8); end
    checks++; if ({z8, n8, h8, c8} !== 4'b0111) begin errors++; $display("FAIL sbc8_flags got %b want 0111", {z8, n8, h8, c8}); end
    step;
    run(1'b0, 3'b100, 16'h003E, 16'h003E, 1'b0, lat, bpre, bd);
    checks++; if (result8 !== 8'h3E) begin errors++; $display("FAIL cp8_result got %h want 3E", result8); end
    checks++; if ({z8, n8, h8, c8} !== 4'b1100) begin errors++; $display("FAIL cp8_flags got %b want 1100", {z8, n8, h8, c8}); end
    step;
    run(1'b0, 3'b001, 16'h00FF, 16'h0000, 1'b1, lat, bpre, bd);
    checks++; if ({result8, z8, n8, h8, c8} !== 12'h0_0B) begin errors++; $display("FAIL adc8 got %h %b want 00 1011", result8, {z8, n8, h8, c8}); end
    step;
  endtask

  task automatic test_add16;
    int lat, bpre; logic bd;
    run(1'b1, 3'b000, 16'h8A23, 16'h0605, 1'b0, lat, bpre, bd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add16_latency got %0d want 5", lat); end
    checks++; if (result16 !== 16'h9028) begin errors++; $display("FAIL add16_result got %h want 9028", result16); end
    checks++; if ({z16, n16, h16, c16} !== 4'b0010) begin errors++; $display("FAIL add16_flags got %b want 0010", {z16, n16, h16, c16}); end
    step;
  endtask

  task automatic test_bcd;
    int lat, bpre; logic bd;
    logic [7:0] exp_r;
`ifdef ALU_SERIAL_BCD_EN
    exp_r = 8'h47;
`else
    exp_r = 8'h41;
`endif
    run(1'b0, 3'b110, 16'h0019, 16'h0028, 1'b0, lat, bpre, bd);
    checks++; if (result8 !== exp_r) begin errors++; $display("FAIL badd_result got %h want %h", result8, exp_r); end
    checks++; if ({z8, n8, h8, c8} !== 4'b0010) begin errors++; $display("FAIL badd_flags got %b want 0010", {z8, n8, h8, c8}); end
    step;
  endtask

  task automatic test_back_to_back;
    logic exp_done, exp_busy;
    logic [7:0] exp_r;
    op = 3'b000; cin = 1'b0; a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    step;
    a8 = 8'h10; b8 = 8'h20;
    for (int c = 1; c <= 8; c++) begin
      exp_done = (c == 3) || (c == 7);
      exp_busy = (c != 4) && (c != 8);
      exp_r    = (c >= 7) ? 8'h30 : 8'h03;
      checks++;
      if (done8 !== exp_done || busy8 !== exp_busy) begin
        errors++; $display("FAIL b2b_handshake cycle %0d got done=%b busy=%b want %b %b", c, done8, busy8, exp_done, exp_busy);
      end
      if (c >= 3) begin
        checks++;
        if (result8 !== exp_r) begin errors++; $display("FAIL b2b_result cycle %0d got %h want %h", c, result8, exp_r); end
      end
      if (c == 8) start8 = 1'b0;
      step;
    end
    repeat (4) step;
  endtask

  task automatic test_reset_mid;
    op = 3'b000; a16 = 16'h1111; b16 = 16'h2222; start16 = 1'b1;
    step;
    start16 = 1'b0;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++;
    if ({busy16, done16, result16, z16, n16, h16, c16} !== 22'h0) begin
      errors++; $display("FAIL reset_mid got %b want 0", {busy16, done16, result16, z16, n16, h16, c16});
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (done16 !== 1'b0 || busy16 !== 1'b0) begin
        errors++; $display("FAIL reset_mid_quiet cycle %0d got done=%b busy=%b want 0 0", c, done16, busy16);
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_add8;
    test_sbc_cp8;
    test_add16;
    test_bcd;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
